// File: rtl/four_inv_sbox_if.sv
// Shared CLM parameter bundle handed to every inverse S-box of the stage.
interface params_if;
  logic [7:0] scramble;

  modport in_use (input scramble);
endinterface

// File: rtl/four_inv_sbox.sv
// Inverse Sub-bytes stage for CLM decryption: four masked inverse S-boxes
// process one word of the 4x4 state per pass, four passes per state.

// Masked inverse S-box. An element is {mask, value ^ mask}; the result is
// re-masked with a byte taken from entry 0 of its randomness vector.
module clm_inv_sbox #(
  parameter int ELEM_W  = 16,
  parameter int R_W     = 16,
  parameter int R_COUNT = 7
) (
  input  logic                        clk,
  input  logic                        rst,
  params_if.in_use                    params,
  input  logic                        drdy_i,
  input  logic                        clear_i,
  input  logic [ELEM_W-1:0]           in_i,
  input  logic [0:R_COUNT-1][R_W-1:0] r_i,
  output logic [ELEM_W-1:0]           out_o,
  output logic                        drdy_o
);

  logic [1:0]        cnt_q;
  logic              done_q;
  logic [ELEM_W-1:0] res_q;
  logic [ELEM_W-1:0] res_d;
  logic [7:0]        plainIn;
  logic [7:0]        invByte;
  logic [7:0]        maskByte;
  logic [1:0]        latency;

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0.
  function automatic logic [7:0] gfInv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = x;
    acc = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gfMul(sq, sq);
      acc = gfMul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] invAffine(input logic [7:0] y);
    return {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
  endfunction

  // Unmask, invert, re-mask; the parity of the other entries stretches the pass by a cycle.
  always_comb begin
    plainIn  = in_i[15:8] ^ in_i[7:0];
    invByte  = gfInv(invAffine(plainIn));
    maskByte = r_i[0][7:0] ^ r_i[0][15:8] ^ params.scramble;
    latency  = (^r_i[1:R_COUNT-1]) ? 2'd2 : 2'd1;
    res_d    = {maskByte, invByte ^ maskByte};
  end

  // Count the pass and hold the result with drdy_o high until the stage takes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= 2'd0;
      done_q <= 1'b0;
      res_q  <= '0;
    end else if (clear_i || !drdy_i) begin
      cnt_q  <= 2'd0;
      done_q <= 1'b0;
    end else if (!done_q) begin
      cnt_q <= cnt_q + 2'd1;
      if (cnt_q == latency - 2'd1) begin
        done_q <= 1'b1;
        res_q  <= res_d;
      end
    end
  end

  assign out_o  = res_q;
  assign drdy_o = done_q;

endmodule

module four_inv_sbox #(
  parameter int ELEM_W  = 16,
  parameter int R_W     = 16,
  parameter int R_COUNT = 7
) (
  input  logic                             clk,
  input  logic                             rst,
  params_if.in_use                         params,
  input  logic                             active,
  input  logic                             load_r,
  input  logic [0:3][0:3][ELEM_W-1:0]      in,
  input  logic [0:R_COUNT-1][R_W-1:0]      random_vect,
  output logic [0:3][0:3][ELEM_W-1:0]      out,
  output logic                             drdy_o,
  output logic                             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef logic [0:R_COUNT-1][R_W-1:0] rvec_t;

  state_t                        state_q;
  logic [1:0]                    col_q;
  rvec_t                         rSaved_q;
  rvec_t                         rSaved_d;
  logic [0:3][0:3][ELEM_W-1:0]   out_q;
  logic                          drdy_q;
  logic                          busy_q;

  logic                          running;
  logic                          sboxDrdy;
  logic                          wordAdvance;
  logic [3:0]                    sboxDone;
  logic [0:3][ELEM_W-1:0]        sboxOut;
  logic [0:3][ELEM_W-1:0]        wordIn;
  rvec_t                         sboxR [4];

  function automatic rvec_t rotVec(input rvec_t v, input int k);
    rvec_t res;
    for (int j = 0; j < R_COUNT; j++) res[j] = v[(j + k) % R_COUNT];
    return res;
  endfunction

  // Handshake decode, per-sbox rotated randomness and the next randomness value.
  always_comb begin
    running     = (state_q == RUN);
    sboxDrdy    = &sboxDone;
    wordAdvance = running && active && sboxDrdy;
    wordIn      = in[col_q];
    for (int i = 0; i < 4; i++) sboxR[i] = rotVec(rSaved_q, i);
    rSaved_d = rSaved_q;
    if (load_r) begin
      rSaved_d = random_vect;
    end else if (wordAdvance) begin
      rSaved_d = rotVec(rSaved_q, 4);
    end
  end

  for (genvar g = 0; g < 4; g++) begin : gSbox
    clm_inv_sbox #(
      .ELEM_W  (ELEM_W),
      .R_W     (R_W),
      .R_COUNT (R_COUNT)
    ) uSbox (
      .clk     (clk),
      .rst     (rst),
      .params  (params),
      .drdy_i  (running),
      .clear_i (wordAdvance),
      .in_i    (wordIn[g]),
      .r_i     (sboxR[g]),
      .out_o   (sboxOut[g]),
      .drdy_o  (sboxDone[g])
    );
  end

  // Stage FSM: walks the four words, collects results and raises the done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      col_q    <= 2'd0;
      rSaved_q <= '0;
      out_q    <= '0;
      drdy_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      drdy_q   <= 1'b0;
      rSaved_q <= rSaved_d;
      case (state_q)
        IDLE: begin
          if (active) begin
            state_q <= RUN;
            col_q   <= 2'd0;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (!active) begin
            state_q <= IDLE;
            col_q   <= 2'd0;
            busy_q  <= 1'b0;
          end else if (sboxDrdy) begin
            for (int i = 0; i < 4; i++) out_q[col_q][i] <= sboxOut[i];
            col_q <= col_q + 2'd1;
            if (col_q == 2'd3) begin
              state_q <= DONE;
              drdy_q  <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
        end
        DONE: begin
          if (active) begin
            state_q <= RUN;
            col_q   <= 2'd0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out    = out_q;
  assign drdy_o = drdy_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_four_inv_sbox.sv
// Self-checking bench for four_inv_sbox against a table-based AES model.
module tb_four_inv_sbox;
  localparam int ELEM_W  = 16;
  localparam int R_W     = 16;
  localparam int R_COUNT = 7;

  logic clk = 1'b0;
  logic rst;
  logic active;
  logic load_r;
  logic [0:3][0:3][ELEM_W-1:0] stateIn;
  logic [0:3][0:3][ELEM_W-1:0] stateOut;
  logic [0:3][0:3][ELEM_W-1:0] prevOut;
  logic [0:3][0:3][ELEM_W-1:0] oldOut;
  logic [0:R_COUNT-1][R_W-1:0] randomVect;
  logic [0:R_COUNT-1][R_W-1:0] vect;
  logic drdy;
  logic busy;

  params_if pif();

  int checks = 0;
  int errors = 0;
  logic [7:0]     sboxTab [256];
  logic [7:0]     invTab  [256];
  logic [R_W-1:0] rModel  [R_COUNT];
  logic [7:0]     plainBytes [4][4];

  four_inv_sbox #(.ELEM_W(ELEM_W), .R_W(R_W), .R_COUNT(R_COUNT)) dut (
    .clk         (clk),
    .rst         (rst),
    .params      (pif),
    .active      (active),
    .load_r      (load_r),
    .in          (stateIn),
    .random_vect (randomVect),
    .out         (stateOut),
    .drdy_o      (drdy),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    int pa = a;
    int pb = b;
    int prod = 0;
    while (pb != 0) begin
      if ((pb & 1) != 0) prod = prod ^ pa;
      pa = pa << 1;
      if ((pa & 'h100) != 0) pa = pa ^ 'h11b;
      pb = pb >> 1;
    end
    return prod[7:0];
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [15:0] encode(input logic [7:0] v, input logic [7:0] m);
    return {m, v ^ m};
  endfunction

  function automatic logic [7:0] decode(input logic [15:0] e);
    return e[15:8] ^ e[7:0];
  endfunction

  // Expected element: inverse S-box of the decoded input, masked by the entry at rotation 'off'.
  function automatic logic [15:0] expElem(input logic [15:0] inElem, input int off);
    logic [15:0] r;
    logic [7:0]  m;
    r = rModel[off % R_COUNT];
    m = r[7:0] ^ r[15:8] ^ pif.scramble;
    return encode(invTab[decode(inElem)], m);
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic loadRandomness(input logic [0:R_COUNT-1][R_W-1:0] v);
    load_r     = 1'b1;
    randomVect = v;
    @(negedge clk);
    load_r = 1'b0;
    for (int j = 0; j < R_COUNT; j++) rModel[j] = v[j];
  endtask

  task automatic makeVect(output logic [0:R_COUNT-1][R_W-1:0] v);
    for (int j = 0; j < R_COUNT; j++) v[j] = 16'($urandom);
  endtask

  // Random plaintext pushed through the forward S-box with fresh masks.
  task automatic makeRoundTrip();
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 4; i++) begin
        plainBytes[c][i] = 8'($urandom);
        stateIn[c][i]    = encode(sboxTab[plainBytes[c][i]], 8'($urandom));
      end
  endtask

  task automatic waitDrdy(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (drdy === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic waitChange(output int col, output bit ok);
    ok  = 1'b0;
    col = -1;
    for (int n = 0; n < 200; n++) begin
      for (int c = 3; c >= 0; c--)
        if (stateOut[c] !== prevOut[c]) col = c;
      if (col >= 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic checkState(input string tag, input int o0, input int o1, input int o2, input int o3);
    int offs [4];
    offs[0] = o0; offs[1] = o1; offs[2] = o2; offs[3] = o3;
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 4; i++)
        checkOutput($sformatf("%s_w%0d_e%0d", tag, c, i), stateOut[c][i],
                    expElem(stateIn[c][i], offs[c] + i));
  endtask

  task automatic checkPlain(input string tag);
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 4; i++)
        checkOutput($sformatf("%s_w%0d_e%0d", tag, c, i), decode(stateOut[c][i]), plainBytes[c][i]);
  endtask

  initial begin
    bit ok;
    bit drdySeen;
    int col;
    int inv;
    logic [7:0] b;
    logic [7:0] s;

    rst        = 1'b0;
    active     = 1'b0;
    load_r     = 1'b0;
    stateIn    = '0;
    randomVect = '0;
    pif.scramble = 8'($urandom);

    for (int x = 0; x < 256; x++) begin
      inv = 0;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(x[7:0], y[7:0]) == 8'h01) inv = y;
      b = inv[7:0];
      s = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
      sboxTab[x] = s;
      invTab[s]  = x[7:0];
    end

    repeat (2) @(negedge clk);
    checkOutput("reset_out", stateOut, '0);
    checkOutput("reset_drdy", drdy, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] known value 0x63 with zero randomness");
    vect = '0;
    loadRandomness(vect);
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 4; i++) stateIn[c][i] = encode(8'h63, 8'($urandom));
    active = 1'b1;
    @(negedge clk);
    checkOutput("kv_busy_run", busy, 1'b1);
    waitDrdy(ok);
    checkOutput("kv_drdy_seen", ok, 1'b1);
    active = 1'b0;
    @(negedge clk);
    checkOutput("kv_drdy_one_cycle", drdy, 1'b0);
    checkOutput("kv_busy_idle", busy, 1'b0);
    checkState("kv", 0, 4, 8, 12);
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 4; i++)
        checkOutput($sformatf("kv_dec_w%0d_e%0d", c, i), decode(stateOut[c][i]), 8'h00);

    $display("[TB] round trip through forward S-box");
    makeVect(vect);
    loadRandomness(vect);
    makeRoundTrip();
    active = 1'b1;
    waitDrdy(ok);
    checkOutput("rt_drdy_seen", ok, 1'b1);
    active = 1'b0;
    @(negedge clk);
    checkState("rt", 0, 4, 8, 12);
    checkPlain("rt_plain");

    $display("[TB] randomness rotation");
    for (int j = 0; j < R_COUNT; j++) vect[j] = 16'(j);
    loadRandomness(vect);
    makeRoundTrip();
    active = 1'b1;
    waitDrdy(ok);
    checkOutput("rot_drdy_seen", ok, 1'b1);
    active = 1'b0;
    @(negedge clk);
    checkOutput("rot_w1_s2_mask", stateOut[1][2][15:8], 8'd6 ^ pif.scramble);
    checkState("rot", 0, 4, 8, 12);

    $display("[TB] load together with word advance");
    makeVect(vect);
    for (int j = 0; j < R_COUNT; j++) rModel[j] = vect[j];
    makeRoundTrip();
    prevOut    = stateOut;
    randomVect = vect;
    load_r     = 1'b1;
    active     = 1'b1;
    waitChange(col, ok);
    load_r = 1'b0;
    checkOutput("lwa_first_col", col, 0);
    waitDrdy(ok);
    checkOutput("lwa_drdy_seen", ok, 1'b1);
    active = 1'b0;
    @(negedge clk);
    checkState("lwa", 0, 0, 4, 8);

    $display("[TB] abort after word 1");
    makeVect(vect);
    loadRandomness(vect);
    makeRoundTrip();
    oldOut  = stateOut;
    prevOut = stateOut;
    active  = 1'b1;
    waitChange(col, ok);
    checkOutput("ab_col0", col, 0);
    prevOut = stateOut;
    waitChange(col, ok);
    checkOutput("ab_col1", col, 1);
    active   = 1'b0;
    drdySeen = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (drdy === 1'b1) drdySeen = 1'b1;
    end
    checkOutput("ab_no_drdy", drdySeen, 1'b0);
    checkOutput("ab_busy", busy, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("ab_w0_e%0d", i), stateOut[0][i], expElem(stateIn[0][i], i));
      checkOutput($sformatf("ab_w1_e%0d", i), stateOut[1][i], expElem(stateIn[1][i], 4 + i));
    end
    checkOutput("ab_w2_kept", stateOut[2], oldOut[2]);
    checkOutput("ab_w3_kept", stateOut[3], oldOut[3]);
    active = 1'b1;
    waitDrdy(ok);
    checkOutput("ab_restart_drdy", ok, 1'b1);
    active = 1'b0;
    @(negedge clk);
    checkState("ab_restart", 8, 12, 16, 20);
    checkPlain("ab_restart_plain");

    $display("[TB] asynchronous reset during word 2");
    makeVect(vect);
    loadRandomness(vect);
    makeRoundTrip();
    prevOut = stateOut;
    active  = 1'b1;
    waitChange(col, ok);
    prevOut = stateOut;
    waitChange(col, ok);
    checkOutput("rs_reached_w1", col, 1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("rs_out", stateOut, '0);
    checkOutput("rs_drdy", drdy, 1'b0);
    checkOutput("rs_busy", busy, 1'b0);
    active = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    loadRandomness(vect);
    prevOut = stateOut;
    active  = 1'b1;
    waitChange(col, ok);
    checkOutput("rs_first_col", col, 0);
    waitDrdy(ok);
    checkOutput("rs_drdy_seen", ok, 1'b1);
    active = 1'b0;
    @(negedge clk);
    checkState("rs", 0, 4, 8, 12);

    $display("[TB] back-to-back states");
    makeVect(vect);
    loadRandomness(vect);
    makeRoundTrip();
    prevOut = stateOut;
    active  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      waitChange(col, ok);
      checkOutput($sformatf("b2b1_order_%0d", k), col, k);
      prevOut = stateOut;
    end
    waitDrdy(ok);
    checkOutput("b2b1_drdy_seen", ok, 1'b1);
    checkState("b2b1", 0, 4, 8, 12);
    makeRoundTrip();
    @(negedge clk);
    checkOutput("b2b1_drdy_one_cycle", drdy, 1'b0);
    prevOut = stateOut;
    for (int k = 0; k < 4; k++) begin
      waitChange(col, ok);
      checkOutput($sformatf("b2b2_order_%0d", k), col, k);
      prevOut = stateOut;
    end
    waitDrdy(ok);
    checkOutput("b2b2_drdy_seen", ok, 1'b1);
    active = 1'b0;
    @(negedge clk);
    checkState("b2b2", 16, 20, 24, 28);
    checkPlain("b2b2_plain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
